// File: rtl/clk_period_meter_if.sv
// Measurement bus for clk_period_meter: enable and slow clock in, measured counts out.
// master drives en/sig_in and observes results; slave is the meter itself.
interface clk_period_meter_if #(
  parameter int WIDTH = 33
);
  logic             en;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             stalled;

  modport master (
    output en,
    output sig_in,
    input  period,
    input  high_time,
    input  valid,
    input  stalled
  );

  modport slave (
    input  en,
    input  sig_in,
    output period,
    output high_time,
    output valid,
    output stalled
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures rise-to-rise period and high time of a slow square wave in clk_in cycles.
// Define CLK_PERIOD_METER_SYNC_EN to sample sig_in through a two-flop synchronizer.
module clk_period_meter #(
  parameter int WIDTH   = 33,
  parameter int TIMEOUT = 100000
) (
  input logic               clk_in,
  input logic               rst,
  clk_period_meter_if.slave bus
);

  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  typedef enum logic {
    SEEK,
    MEASURE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             s;
  logic             s_d;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] hcnt;
  logic [WIDTH-1:0] hcnt_next;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] period_next;
  logic [WIDTH-1:0] high_q;
  logic [WIDTH-1:0] high_next;
  logic             valid_q;
  logic             valid_next;
  logic             stalled_q;
  logic             stalled_next;

`ifdef CLK_PERIOD_METER_SYNC_EN
  logic m1;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      m1 <= bus.sig_in;
      s  <= m1;
    end
  end
`else
  // Only safe when sig_in is already generated in the clk_in domain
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) s <= 1'b0;
    else     s <= bus.sig_in;
  end
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

  assign rise = s & ~s_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= SEEK;
    else     state <= state_next;
  end

  // Priority: en low, then rise, then timeout; a rise on the timeout cycle still measures
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    hcnt_next    = hcnt;
    period_next  = period_q;
    high_next    = high_q;
    valid_next   = 1'b0;
    stalled_next = stalled_q;
    if (!bus.en) begin
      state_next = SEEK;
      cnt_next   = '0;
      hcnt_next  = '0;
    end else begin
      case (state)
        SEEK: begin
          if (rise) begin
            state_next = MEASURE;
            cnt_next   = ONE;
            hcnt_next  = ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_next  = cnt;
            high_next    = hcnt;
            valid_next   = 1'b1;
            stalled_next = 1'b0;
            cnt_next     = ONE;
            hcnt_next    = ONE;
          end else if (cnt == TIMEOUT_CNT) begin
            stalled_next = 1'b1;
            state_next   = SEEK;
            cnt_next     = '0;
            hcnt_next    = '0;
          end else begin
            cnt_next = cnt + ONE;
            if (s) hcnt_next = hcnt + ONE;
          end
        end
        default: begin
          state_next = SEEK;
          cnt_next   = '0;
          hcnt_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      hcnt      <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      hcnt      <= hcnt_next;
      period_q  <= period_next;
      high_q    <= high_next;
      valid_q   <= valid_next;
      stalled_q <= stalled_next;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.stalled   = stalled_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: two meters (timeouts 50 and 10) share one stimulus and
// are checked every cycle against a timestamp-based reference model plus directed checks.
module tb_clk_period_meter;

  localparam int WIDTH = 33;
`ifdef CLK_PERIOD_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic en     = 1'b1;
  logic sig_in = 1'b0;

  int check_count = 0;
  int error_count = 0;

  clk_period_meter_if #(.WIDTH(WIDTH)) bus_a ();
  clk_period_meter_if #(.WIDTH(WIDTH)) bus_b ();

  assign bus_a.en     = en;
  assign bus_a.sig_in = sig_in;
  assign bus_b.en     = en;
  assign bus_b.sig_in = sig_in;

  clk_period_meter #(.WIDTH(WIDTH), .TIMEOUT(50)) dut_a (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus_a)
  );

  clk_period_meter #(.WIDTH(WIDTH), .TIMEOUT(10)) dut_b (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus_b)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the meter sees sig_in LAT samples late; a measurement is the time
  // between two seen rises and the number of seen-high cycles in [rise, next rise).
  int     to_val [2] = '{50, 10};
  logic   [2:0] hist = '0;
  longint now = 0;
  longint cum = 0;
  logic   armed [2];
  longint rise_at [2];
  longint cum_at [2];
  longint exp_period [2];
  longint exp_high [2];
  logic   exp_valid [2];
  logic   exp_stalled [2];
  logic   s_seen;
  logic   s_prev;
  logic   seen_rise;

  always @(posedge clk_in) begin
    if (rst) begin
      hist = '0;
      for (int i = 0; i < 2; i++) begin
        armed[i]       = 1'b0;
        rise_at[i]     = 0;
        cum_at[i]      = 0;
        exp_period[i]  = 0;
        exp_high[i]    = 0;
        exp_valid[i]   = 1'b0;
        exp_stalled[i] = 1'b0;
      end
    end else begin
      s_seen    = hist[LAT-1];
      s_prev    = hist[LAT];
      seen_rise = s_seen & ~s_prev;
      for (int i = 0; i < 2; i++) begin
        exp_valid[i] = 1'b0;
        if (!en) begin
          armed[i] = 1'b0;
        end else if (seen_rise) begin
          if (armed[i]) begin
            exp_period[i]  = now - rise_at[i];
            exp_high[i]    = cum - cum_at[i];
            exp_valid[i]   = 1'b1;
            exp_stalled[i] = 1'b0;
          end
          armed[i]   = 1'b1;
          rise_at[i] = now;
          cum_at[i]  = cum;
        end else if (armed[i] && (now - rise_at[i] == longint'(to_val[i]))) begin
          exp_stalled[i] = 1'b1;
          armed[i]       = 1'b0;
        end
      end
      if (s_seen) cum++;
      hist = {hist[1:0], sig_in};
    end
    now++;
    #1;
    checkOutput("valid_a",     longint'(bus_a.valid),     longint'(exp_valid[0]));
    checkOutput("stalled_a",   longint'(bus_a.stalled),   longint'(exp_stalled[0]));
    checkOutput("period_a",    longint'(bus_a.period),    exp_period[0]);
    checkOutput("high_time_a", longint'(bus_a.high_time), exp_high[0]);
    checkOutput("valid_b",     longint'(bus_b.valid),     longint'(exp_valid[1]));
    checkOutput("stalled_b",   longint'(bus_b.stalled),   longint'(exp_stalled[1]));
    checkOutput("period_b",    longint'(bus_b.period),    exp_period[1]);
    checkOutput("high_time_b", longint'(bus_b.high_time), exp_high[1]);
  end

  // Square wave starting with its high phase; en drops for 4 cycles from drop_at (if >= 0)
  task automatic applyStimulus(input int high, input int low, input int periods, input int drop_at);
    for (int c = 0; c < (high + low) * periods; c++) begin
      sig_in = ((c % (high + low)) < high);
      en     = !(drop_at >= 0 && c >= drop_at && c < drop_at + 4);
      @(negedge clk_in);
    end
    en = 1'b1;
  endtask

  task automatic measureLatency();
    int lat;
    lat    = 0;
    sig_in = 1'b1;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk_in);
      #1;
      if (bus_a.valid) lat = k;
    end
    checkOutput("rise_to_valid_latency", longint'(lat), longint'(LAT + 1));
    @(negedge clk_in);
  endtask

  initial begin
    int h;
    int l;
    int p;
    int d;
    $display("[TB] start, synchronizer stages = %0d", LAT);
    repeat (3) @(negedge clk_in);
    rst = 1'b0;

    applyStimulus(5, 5, 4, -1);
    checkOutput("square_period", longint'(bus_a.period), 10);
    checkOutput("square_high",   longint'(bus_a.high_time), 5);

    applyStimulus(3, 7, 4, -1);
    checkOutput("duty_period", longint'(bus_a.period), 10);
    checkOutput("duty_high",   longint'(bus_a.high_time), 3);

    measureLatency();

    applyStimulus(5, 5, 2, -1);
    sig_in = 1'b0;
    repeat (60) @(negedge clk_in);
    checkOutput("timeout_stalled", longint'(bus_a.stalled), 1);
    applyStimulus(5, 5, 2, -1);
    checkOutput("resume_stalled", longint'(bus_a.stalled), 0);
    checkOutput("resume_period",  longint'(bus_a.period), 10);

    applyStimulus(5, 5, 4, 13);
    checkOutput("en_drop_period", longint'(bus_a.period), 10);

    applyStimulus(5, 5, 4, -1);
    checkOutput("collision_period",  longint'(bus_b.period), 10);
    checkOutput("collision_stalled", longint'(bus_b.stalled), 0);

    applyStimulus(5, 5, 1, -1);
    sig_in = 1'b1;
    @(negedge clk_in);
    rst = 1'b1;
    #1;
    checkOutput("rst_period_a",  longint'(bus_a.period), 0);
    checkOutput("rst_high_a",    longint'(bus_a.high_time), 0);
    checkOutput("rst_valid_a",   longint'(bus_a.valid), 0);
    checkOutput("rst_stalled_a", longint'(bus_a.stalled), 0);
    checkOutput("rst_period_b",  longint'(bus_b.period), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;

    for (int it = 0; it < 16; it++) begin
      h = $urandom_range(1, 15);
      l = $urandom_range(1, 15);
      p = $urandom_range(2, 5);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (h + l) * p - 5) : -1;
      applyStimulus(h, l, p, d);
      if ($urandom_range(0, 4) == 0) begin
        sig_in = 1'b0;
        repeat ($urandom_range(10, 70)) @(negedge clk_in);
      end
    end

    sig_in = 1'b0;
    repeat (5) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", check_count, error_count);
    $finish;
  end

endmodule
